// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : handshaked sequential ALU with iterative multiply and divide.
//
// Base ops (ZERO..SEQ) finish on the accepting edge. MUL/MULH/MULHU run
// WIDTH shift-add steps. DIV/DIVU/REM/REMU run WIDTH restoring-divide steps.
// The result is registered and held until the consumer takes it.
//
// Optional feature macro: ALU_SEQ_DIV_EN
//   defined   -> ops 15..18 use the iterative divider (DIV state)
//   undefined -> no divider logic; ops 15..18 are reported as illegal
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid / in_ready input handshake; op, lhs, rhs captured on transfer
//   out_valid/out_ready output handshake; out, out_bit0, out_illegal held
//                       stable while out_valid & !out_ready
//   busy                high while a multiply or divide is iterating
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_bit0,
    output logic             out_illegal,
    output logic             busy
);

    localparam logic [4:0] OP_ZERO  = 5'd0,  OP_ADD   = 5'd1,  OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3,  OP_SLTU  = 5'd4,  OP_XOR  = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6,  OP_AND   = 5'd7,  OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9,  OP_SRA   = 5'd10, OP_SEQ  = 5'd11;
    localparam logic [4:0] OP_MUL   = 5'd12, OP_MULH  = 5'd13, OP_MULHU = 5'd14;
    localparam logic [4:0] OP_DIV   = 5'd15, OP_DIVU  = 5'd16, OP_REM  = 5'd17;
    localparam logic [4:0] OP_REMU  = 5'd18;
    localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
`ifdef ALU_SEQ_DIV_EN
        , ST_DIV = 2'd3
`endif
    } state_t;

    // Magnitude of v, treating it as two's complement only when sgn is set.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) mag = ~v + WIDTH'(1);
        else                   mag = v;
    endfunction

    state_t              state_r, state_s;
    logic [WIDTH-1:0]    out_r;
    logic                illegal_r;
    logic [WIDTH-1:0]    acc_r;    // partial product high half / partial remainder
    logic [WIDTH-1:0]    lo_r;     // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0]    opd_r;    // multiplicand / divisor magnitude
    logic [SHAMT_W-1:0]  cnt_r;
    logic [4:0]          op_r;
    logic                neg_r;    // final result must be negated
    logic                accept_s, is_mul_s;
    logic [WIDTH-1:0]    base_res_s;
    logic                base_legal_s;
    logic [WIDTH:0]      mul_sum_s;
    logic [WIDTH-1:0]    mul_acc_s, mul_lo_s, mul_res_s;
    logic [2*WIDTH-1:0]  prod_s, prod_f_s;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]    lhs_r;    // original dividend, returned as remainder on /0
    logic                zero_r;   // divisor was zero
    logic                is_div_s;
    logic [WIDTH:0]      div_shift_s, div_trial_s;
    logic [WIDTH-1:0]    div_acc_s, div_lo_s, div_quo_s, div_rem_s, div_res_s;
`endif

    assign in_ready    = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign accept_s    = in_valid & in_ready;
    assign is_mul_s    = (op >= OP_MUL) && (op <= OP_MULHU);
    assign out_valid   = (state_r == ST_DONE);
    assign out         = out_r;
    assign out_bit0    = out_r[0];
    assign out_illegal = illegal_r;
`ifdef ALU_SEQ_DIV_EN
    assign is_div_s    = (op >= OP_DIV) && (op <= OP_REMU);
    assign busy        = (state_r == ST_MUL) | (state_r == ST_DIV);
`else
    assign busy        = (state_r == ST_MUL);
`endif

    // Single-cycle base operation result and legality decode.
    always_comb begin
        base_res_s   = {WIDTH{1'b0}};
        base_legal_s = 1'b1;
        case (op)
            OP_ZERO: base_res_s = {WIDTH{1'b0}};
            OP_ADD:  base_res_s = lhs + rhs;
            OP_SUB:  base_res_s = lhs - rhs;
            OP_SLT:  base_res_s = {{(WIDTH-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
            OP_SLTU: base_res_s = {{(WIDTH-1){1'b0}}, (lhs < rhs)};
            OP_XOR:  base_res_s = lhs ^ rhs;
            OP_OR:   base_res_s = lhs | rhs;
            OP_AND:  base_res_s = lhs & rhs;
            OP_SLL:  base_res_s = lhs << rhs[SHAMT_W-1:0];
            OP_SRL:  base_res_s = lhs >> rhs[SHAMT_W-1:0];
            OP_SRA:  base_res_s = $signed(lhs) >>> rhs[SHAMT_W-1:0];
            OP_SEQ:  base_res_s = {{(WIDTH-1){1'b0}}, (lhs == rhs)};
            default: base_legal_s = 1'b0;
        endcase
    end

    // One shift-add step: add multiplicand when the current multiplier bit is
    // set, then shift the {acc, lo} pair right by one.
    always_comb begin
        mul_sum_s = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
        mul_acc_s = mul_sum_s[WIDTH:1];
        mul_lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        prod_s    = {mul_acc_s, mul_lo_s};
        if (neg_r) prod_f_s = ~prod_s + (2*WIDTH)'(1);
        else       prod_f_s = prod_s;
        if (op_r == OP_MUL) mul_res_s = prod_f_s[WIDTH-1:0];
        else                mul_res_s = prod_f_s[2*WIDTH-1:WIDTH];
    end

`ifdef ALU_SEQ_DIV_EN
    // One restoring-divide step plus the sign/boundary fix-up of the result.
    always_comb begin
        div_shift_s = {acc_r, lo_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opd_r};
        if (!div_trial_s[WIDTH]) begin
            div_acc_s = div_trial_s[WIDTH-1:0];
            div_lo_s  = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_s = div_shift_s[WIDTH-1:0];
            div_lo_s  = {lo_r[WIDTH-2:0], 1'b0};
        end
        // Most-negative / -1 needs no special case: the magnitude quotient
        // 2^(WIDTH-1) negates back onto itself and the remainder is 0.
        if (zero_r)     div_quo_s = {WIDTH{1'b1}};
        else if (neg_r) div_quo_s = ~div_lo_s + WIDTH'(1);
        else            div_quo_s = div_lo_s;
        if (zero_r)     div_rem_s = lhs_r;
        else if (neg_r) div_rem_s = ~div_acc_s + WIDTH'(1);
        else            div_rem_s = div_acc_s;
        if ((op_r == OP_DIV) || (op_r == OP_DIVU)) div_res_s = div_quo_s;
        else                                       div_res_s = div_rem_s;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (is_mul_s) state_s = ST_MUL;
`ifdef ALU_SEQ_DIV_EN
                    else if (is_div_s) state_s = ST_DIV;
`endif
                    else state_s = ST_DONE;
                end else if ((state_r == ST_DONE) && out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_MUL: begin
                if (cnt_r == LAST_STEP) state_s = ST_DONE;
                else                    state_s = ST_MUL;
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
                if (cnt_r == LAST_STEP) state_s = ST_DONE;
                else                    state_s = ST_DIV;
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // State, operand capture, iteration datapath and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            out_r     <= {WIDTH{1'b0}};
            illegal_r <= 1'b0;
            acc_r     <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            opd_r     <= {WIDTH{1'b0}};
            cnt_r     <= {SHAMT_W{1'b0}};
            op_r      <= 5'd0;
            neg_r     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            lhs_r     <= {WIDTH{1'b0}};
            zero_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        op_r  <= op;
                        acc_r <= {WIDTH{1'b0}};
                        cnt_r <= {SHAMT_W{1'b0}};
                        if (is_mul_s) begin
                            lo_r  <= mag(rhs, op == OP_MULH);
                            opd_r <= mag(lhs, op == OP_MULH);
                            neg_r <= (op == OP_MULH) & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
                        end else if (is_div_s) begin
                            lo_r   <= mag(lhs, (op == OP_DIV) || (op == OP_REM));
                            opd_r  <= mag(rhs, (op == OP_DIV) || (op == OP_REM));
                            neg_r  <= ((op == OP_DIV) & (lhs[WIDTH-1] ^ rhs[WIDTH-1]))
                                    | ((op == OP_REM) & lhs[WIDTH-1]);
                            lhs_r  <= lhs;
                            zero_r <= (rhs == {WIDTH{1'b0}});
`endif
                        end else begin
                            out_r     <= base_legal_s ? base_res_s : {WIDTH{1'b0}};
                            illegal_r <= ~base_legal_s;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= mul_acc_s;
                    lo_r  <= mul_lo_s;
                    cnt_r <= cnt_r + SHAMT_W'(1);
                    if (cnt_r == LAST_STEP) begin
                        out_r     <= mul_res_s;
                        illegal_r <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    acc_r <= div_acc_s;
                    lo_r  <= div_lo_s;
                    cnt_r <= cnt_r + SHAMT_W'(1);
                    if (cnt_r == LAST_STEP) begin
                        out_r     <= div_res_s;
                        illegal_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    cnt_r <= {SHAMT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH = 32).
// Expected values are hand-computed constants. Divide expectations follow
// ALU_SEQ_DIV_EN: with the macro undefined, ops 15..18 must come back illegal.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'd0;
    logic [31:0] lhs = 32'd0;
    logic [31:0] rhs = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        out_bit0;
    logic        out_illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .lhs(lhs), .rhs(rhs), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_bit0(out_bit0), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready=1, scramble inputs after accept, then
    // measure latency and busy cycles and check the result.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out,
                          input logic exp_ill, input int exp_lat, input int exp_busy);
        int n;
        int nb;
        @(negedge clk);
        op = o; lhs = a; rhs = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 5'd1; lhs = 32'hDEADBEEF; rhs = 32'h12345678;
        n = 0;
        nb = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (busy) nb++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy"}, 32'(nb), 32'(exp_busy));
        check({tag, "_out"}, out, exp_out);
        check({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, exp_ill});
        check({tag, "_bit0"}, {31'd0, out_bit0}, {31'd0, exp_out[0]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_illegal", {31'd0, out_illegal}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: ADD then SLT accepted in the DONE cycle.
        @(negedge clk);
        op = 5'd1; lhs = 32'h7FFFFFFF; rhs = 32'h00000001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_add_out", out, 32'h80000000);
        check("b2b_add_ill", {31'd0, out_illegal}, 32'd0);
        check("b2b_add_rdy", {31'd0, in_ready}, 32'd1);
        op = 5'd3; lhs = 32'hFFFFFFFF; rhs = 32'h00000001;
        @(negedge clk);
        check("b2b_slt_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_slt_out", out, 32'h00000001);
        in_valid = 1'b0;

        // Base ops.
        run_op("zero", 5'd0,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1, 0);
        run_op("sub",  5'd2,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1, 0);
        run_op("slt",  5'd3,  32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 0);
        run_op("sltu", 5'd4,  32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 0);
        run_op("xor",  5'd5,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1, 0);
        run_op("or",   5'd6,  32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1, 0);
        run_op("and",  5'd7,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1, 0);
        run_op("sll",  5'd8,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1, 0);
        run_op("srl",  5'd9,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 1, 0);
        run_op("seq",  5'd11, 32'd5,        32'd5,        32'h00000001, 1'b0, 1, 0);
        run_op("ill25", 5'd25, 32'd5,       32'd5,        32'h00000000, 1'b1, 1, 0);

        // Multiply.
        run_op("mul",   5'd12, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 33, 32);
        run_op("mulh",  5'd13, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33, 32);
        run_op("mulhn", 5'd13, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 1'b0, 33, 32);
        run_op("mulhu", 5'd14, 32'hFFFFFFFF, 32'd2,        32'h00000001, 1'b0, 33, 32);

        // Divide.
`ifdef ALU_SEQ_DIV_EN
        run_op("div",   5'd15, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33, 32);
        run_op("rem",   5'd17, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33, 32);
        run_op("divu0", 5'd16, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 33, 32);
        run_op("rem0",  5'd17, 32'd5,        32'd0,        32'h00000005, 1'b0, 33, 32);
        run_op("divov", 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, 32);
        run_op("remu",  5'd18, 32'd100,      32'd7,        32'h00000002, 1'b0, 33, 32);
`else
        run_op("div",   5'd15, 32'hFFFFFFF9, 32'd2,        32'h00000000, 1'b1, 1, 0);
        run_op("divu",  5'd16, 32'd5,        32'd0,        32'h00000000, 1'b1, 1, 0);
        run_op("rem",   5'd17, 32'hFFFFFFF9, 32'd2,        32'h00000000, 1'b1, 1, 0);
        run_op("remu",  5'd18, 32'd100,      32'd7,        32'h00000000, 1'b1, 1, 0);
`endif

        // Backpressure on SRA.
        @(negedge clk);
        op = 5'd10; lhs = 32'h80000000; rhs = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; lhs = 32'd0; rhs = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out", out, 32'hF8000000);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        check("bp_release_out", out, 32'hF8000000);

        // Reset in the middle of an iterative op.
        @(negedge clk);
`ifdef ALU_SEQ_DIV_EN
        op = 5'd16;
`else
        op = 5'd14;
`endif
        lhs = 32'd1000; rhs = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_add", 5'd1, 32'd40, 32'd2, 32'd42, 1'b0, 1, 0);
        run_op("post_rst_mulhu", 5'd14, 32'h80000000, 32'd4, 32'h00000002, 1'b0, 33, 32);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
